alu_result_buffer: RTL
======================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries; power of two, >= 2.
REQ-002 Parameter DEST_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  logic-ALU result is present this cycle.
REQ-006 in_ready  output  1  buffer accepts a result this cycle.
REQ-007 in_result  input  32  logic-ALU output word (AND/XOR result).
REQ-008 in_sel  input  1  ALU op that produced the result: 0 = AND, 1 = XOR.
REQ-009 in_dest  input  DEST_W  destination register index.
REQ-010 out_valid  output  1  head entry available to writeback.
REQ-011 out_ready  input  1  writeback consumes the head entry.
REQ-012 out_result  output  32  head entry result.
REQ-013 out_sel  output  1  head entry op code.
REQ-014 out_dest  output  DEST_W  head entry destination index.
REQ-015 out_zero  output  1  head result == 0 (present only with ALU_RESULT_FLAGS_EN).
REQ-016 out_parity  output  1  XOR-reduction of head result (present only with ALU_RESULT_FLAGS_EN).
REQ-017 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Push occurs on a clock edge where in_valid && in_ready; pop occurs where out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < DEPTH) && !rst, derived from registered state only; no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 Latency: an entry pushed into an empty buffer at edge N SHALL appear on out_* with out_valid=1 after edge N; no same-cycle bypass.
REQ-022 Entries SHALL be delivered in push order; read/write pointers wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-024 Full (count == DEPTH): in_ready=0, in_valid ignored; a pop that edge frees one entry, in_ready=1 next cycle.
REQ-025 Empty: out_ready ignored, count never underflows; out_result, out_sel, out_dest, flags SHALL read 0.
REQ-026 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-027 Count SHALL update as count + push - pop each edge.

Reset
REQ-028 rst assertion SHALL immediately clear pointers, count, and all storage to 0, independent of clk.
REQ-029 During reset: in_ready=0, out_valid=0, out_result=0, out_sel=0, out_dest=0, out_zero=0, out_parity=0, count=0.
REQ-030 Reset mid-operation SHALL discard all entries; no push accepted on the edge where rst is high.
REQ-031 First push is accepted on the first edge after rst deasserts.

Configuration
REQ-032 Macro ALU_RESULT_FLAGS_EN defined: zero and parity flags computed from in_result at push, stored per entry, presented as out_zero/out_parity with the head entry.
REQ-033 Macro ALU_RESULT_FLAGS_EN undefined: out_zero/out_parity ports and flag storage absent; all other behaviour identical.

Structure
REQ-034 Shared package alu_pkg SHALL hold DATA_W=32, default DEPTH, default DEST_W, ALU op encoding constants (OP_AND=0, OP_XOR=1), and the entry typedef {result, sel, dest, flags}.
REQ-035 Flag computation SHALL reside in one sub-module alu_flag_gen (32-bit in; zero, parity out).
REQ-036 Storage, pointers and count remain in alu_result_buffer.

Verification
REQ-037 Reset then single push {result=32'h0000_00F0, sel=0, dest=3}, out_ready=0 -> next cycle out_valid=1, out_result=32'h0000_00F0, out_dest=3, count=1, out_zero=0, out_parity=0.
REQ-038 Push 4 results 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; fifth push value 5 dropped; drain yields 1,2,3,4 in order.
REQ-039 Full buffer, in_valid=1 and out_ready=1 same edge -> pop only, count=3, in_ready=1 next cycle, subsequent push accepted.
REQ-040 count=2, simultaneous push/pop for 10 cycles across pointer wrap -> count stays 2, sequence intact.
REQ-041 Push result=0, sel=1 (flags build) -> out_zero=1, out_parity=0, out_sel=1; push 32'h0000_0007 -> out_parity=1.
REQ-042 count=3, assert rst asynchronously between edges -> count=0, out_valid=0, in_ready=0 immediately; after release buffer behaves as empty.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the logic-ALU result buffer: widths, op codes, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional flag fields are present only when ALU_RESULT_FLAGS_EN is defined.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DEST_W = 5;

  // Logic-ALU op encoding carried in the sel field
  localparam logic OP_AND = 1'b0;
  localparam logic OP_XOR = 1'b1;

  typedef struct packed {
    logic zero;
    logic parity;
  } flags_t;

  // Buffer entry at the default destination width
  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic                  sel;
    logic [DEF_DEST_W-1:0] dest;
`ifdef ALU_RESULT_FLAGS_EN
    flags_t                flags;
`endif
  } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Zero/parity flag generation for a logic-ALU result word (built only with ALU_RESULT_FLAGS_EN).
// Latency: purely combinational.
// Backpressure: none; flags follow the input word.
`ifdef ALU_RESULT_FLAGS_EN
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              parity
);

  // Zero when no bit is set; parity is the XOR of all bits
  always_comb begin
    zero   = ~|result;
    parity = ^result;
  end

endmodule
`endif

// File: rtl/alu_result_buffer.sv
// In-order result buffer between the logic ALU and writeback; optional flags via ALU_RESULT_FLAGS_EN.
// Latency: a push at edge N is visible on out_* after edge N (no same-cycle bypass).
// Backpressure: in_ready drops when all DEPTH entries are occupied; out_* hold while out_ready is low.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DEST_W = DEF_DEST_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_sel,
  input  logic [DEST_W-1:0]      in_dest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic                   out_sel,
  output logic [DEST_W-1:0]      out_dest,
`ifdef ALU_RESULT_FLAGS_EN
  output logic                   out_zero,
  output logic                   out_parity,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Same layout as alu_pkg::entry_t, but with the instance's destination width
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              sel;
    logic [DEST_W-1:0] dest;
`ifdef ALU_RESULT_FLAGS_EN
    flags_t            flags;
`endif
  } slot_t;

  slot_t             mem [DEPTH];
  slot_t             wr_entry;
  slot_t             head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

`ifdef ALU_RESULT_FLAGS_EN
  logic in_zero;
  logic in_parity;

  alu_flag_gen u_flag_gen (
    .result (in_result),
    .zero   (in_zero),
    .parity (in_parity)
  );
`endif

  // Handshake: readiness comes from occupancy alone, never from out_ready
  always_comb begin
    in_ready  = (count < CNT_W'(DEPTH)) && !rst;
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Assemble the entry written on a push
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = in_result;
    wr_entry.sel    = in_sel;
    wr_entry.dest   = in_dest;
`ifdef ALU_RESULT_FLAGS_EN
    wr_entry.flags.zero   = in_zero;
    wr_entry.flags.parity = in_parity;
`endif
  end

  // Storage, pointers and occupancy; reset wipes everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head presentation; an empty buffer shows all zeros rather than stale storage
  always_comb begin
    head       = out_valid ? mem[rd_ptr] : '0;
    out_result = head.result;
    out_sel    = head.sel;
    out_dest   = head.dest;
`ifdef ALU_RESULT_FLAGS_EN
    out_zero   = head.flags.zero;
    out_parity = head.flags.parity;
`endif
  end

endmodule
